avalon_st_packet_arbiter: RTL and testbench
===========================================

// Module: avalon_st_packet_arbiter
// PURPOSE
//  Packet-granular round-robin arbiter that shares one Avalon-ST datapath between NUM_IN sources.
//  Payload per beat: 32b data, 6b error, sop, eop, 2b empty.
//  Sits upstream of the ready-latency timing adapter in the DE4 SOPC streaming fabric.
//  Once granted, a source holds the link until its eop beat is accepted; packets are never interleaved.
// PARAMETERS
//  NUM_IN   4   number of requesting sources (2..8)
//  DATA_W   32  data width per beat
//  ERR_W    6   error width per beat
//  EMPTY_W  2   empty-symbol count width
//  CHAN_W   2   channel id width, = clog2(NUM_IN)
// PORTS
//  clk                in   1                 clock
//  reset_n            in   1                 asynchronous, active-low reset
//  in_valid           in   NUM_IN            per-source valid
//  in_ready           out  NUM_IN            per-source ready (ready latency 0)
//  in_data            in   NUM_IN*DATA_W     source i occupies bits [i*DATA_W +: DATA_W]
//  in_error           in   NUM_IN*ERR_W      per-source error, packed as in_data
//  in_startofpacket   in   NUM_IN            per-source sop
//  in_endofpacket     in   NUM_IN            per-source eop
//  in_empty           in   NUM_IN*EMPTY_W    per-source empty
//  out_ready          in   1                 sink ready (ready latency 0)
//  out_valid          out  1                 muxed valid
//  out_data/out_error/out_startofpacket/out_endofpacket/out_empty  out  as one source  muxed payload
//  out_channel        out  CHAN_W            index of the granted source
//  proto_err          out  1                 sticky protocol-violation flag
//  proto_err_clr      in   1                 synchronous clear of proto_err
// BEHAVIOUR
//  Reset (reset_n=0, async): state=IDLE; out_valid=0; in_ready=0; out_channel=0; proto_err=0;
//   rr_ptr=NUM_IN-1, so source 0 has first priority. Payload outputs are don't-care while out_valid=0.
//  Reset mid-packet aborts the packet; the downstream sink sees no eop.
//  States: IDLE, BUSY.
//  IDLE:
//   - req[i] = in_valid[i] & in_startofpacket[i].
//   - If req!=0, the winner is the first set req after rr_ptr (wrapping modulo NUM_IN).
//   - Register grant <= winner and go to BUSY on the next edge.
//   - in_ready=0 and out_valid=0 for all sources: one bubble cycle per packet.
//   - A source with valid=1 and sop=0 is not a request; it stalls and sets proto_err.
//  BUSY (grant=g):
//   - Outputs are combinational from source g: out_valid=in_valid[g], out_* = source g payload.
//   - in_ready[g]=out_ready; in_ready[j!=g]=0; out_channel=g.
//   - Beat accepted = in_valid[g] & out_ready.
//   - Accepted beat with eop=1: next state IDLE, rr_ptr<=g.
//   - Accepted beat with sop=1 after the first beat (missing eop): beat is forwarded and proto_err set.
//  Latency: zero cycles for data once in BUSY; 1 cycle from request to first beat.
//  Single-beat packet (sop&eop): BUSY lasts one accepting cycle, then IDLE.
//  out_ready=0 in BUSY: hold state and the grant indefinitely; no beat is lost.
//  Simultaneous proto_err set and proto_err_clr: set wins.
//  Fairness: each source waits at most NUM_IN-1 packets while it holds sop.
// STRUCTURE
//  Shared package: localparams DATA_W/ERR_W/EMPTY_W, payload width (42), state encoding
//   (IDLE=1'b0, BUSY=1'b1).
//  Sub-module rr_arbiter (NUM_IN): inputs req and rr_ptr; outputs one-hot grant and its index;
//   purely combinational.
//  Top level holds the FSM, grant register, rr_ptr, payload mux and proto_err.
// TESTING
//  1 Only src0 sends 3-beat pkt, out_ready=1 -> idle cycle, then 3 beats on out, channel=0, back to IDLE.
//  2 All 4 sources hold 1-beat pkts from reset -> output channel order 0,1,2,3,0.
//  3 src1 mid-pkt, out_ready toggles 1,0,0,1 -> beats held stable while stalled, none duplicated.
//  4 src2 valid without sop in IDLE -> src2 in_ready=0, proto_err=1; proto_err_clr -> 0.
//  5 src3 sends sop, sop (no eop) -> second beat forwarded and proto_err=1.
//  6 reset_n low during beat 2 of 4 -> out_valid=0 at once; after release, src0 wins first.
//  Bench checks: no interleaving on out_channel within sop..eop; valid&!ready payload stable.

Source files
------------

// File: rtl/avalon_st_packet_arbiter_pkg.sv
// Shared widths and state encoding for the Avalon-ST packet arbiter.
package avalon_st_packet_arbiter_pkg;

    localparam int DATA_W    = 32;
    localparam int ERR_W     = 6;
    localparam int EMPTY_W   = 2;
    localparam int PAYLOAD_W = DATA_W + ERR_W + 2 + EMPTY_W;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

endpackage

// File: rtl/avalon_st_packet_arbiter_rr_arbiter.sv
// Combinational round-robin picker: the first set request strictly after rr_ptr wins.
module rr_arbiter #(
    parameter int NUM_IN = 4,
    parameter int CHAN_W = $clog2(NUM_IN)
) (
    input  logic [NUM_IN-1:0] req,
    input  logic [CHAN_W-1:0] rr_ptr,
    output logic [NUM_IN-1:0] grant,
    output logic [CHAN_W-1:0] grant_idx
);

    logic              found;
    logic [CHAN_W-1:0] cand;

    // Scan from rr_ptr+1 around to rr_ptr itself, so the last winner has lowest priority.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        cand      = '0;
        for (int k = 1; k <= NUM_IN; k++) begin
            cand = CHAN_W'((int'(rr_ptr) + k) % NUM_IN);
            if (!found && req[cand]) begin
                found       = 1'b1;
                grant_idx   = cand;
                grant[cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/avalon_st_packet_arbiter.sv
// Packet-granular round-robin arbiter sharing one Avalon-ST link between NUM_IN sources.
module avalon_st_packet_arbiter
    import avalon_st_packet_arbiter_pkg::*;
#(
    parameter int NUM_IN = 4,
    parameter int CHAN_W = $clog2(NUM_IN)
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic [NUM_IN-1:0]           in_valid,
    output logic [NUM_IN-1:0]           in_ready,
    input  logic [NUM_IN*DATA_W-1:0]    in_data,
    input  logic [NUM_IN*ERR_W-1:0]     in_error,
    input  logic [NUM_IN-1:0]           in_startofpacket,
    input  logic [NUM_IN-1:0]           in_endofpacket,
    input  logic [NUM_IN*EMPTY_W-1:0]   in_empty,
    input  logic                        out_ready,
    output logic                        out_valid,
    output logic [DATA_W-1:0]           out_data,
    output logic [ERR_W-1:0]            out_error,
    output logic                        out_startofpacket,
    output logic                        out_endofpacket,
    output logic [EMPTY_W-1:0]          out_empty,
    output logic [CHAN_W-1:0]           out_channel,
    output logic                        proto_err,
    input  logic                        proto_err_clr
);

    state_t              state_q, state_d;
    logic [CHAN_W-1:0]   grant_q, grant_d;
    logic [CHAN_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic                mid_pkt_q, mid_pkt_d;
    logic                proto_err_q, proto_err_d;

    logic [NUM_IN-1:0]    req;
    logic [NUM_IN-1:0]    arb_onehot;
    logic [CHAN_W-1:0]    arb_idx;
    logic [PAYLOAD_W-1:0] payload [NUM_IN];
    logic [PAYLOAD_W-1:0] sel_payload;
    logic                 accept;

    assign req = in_valid & in_startofpacket;

    rr_arbiter #(
        .NUM_IN (NUM_IN),
        .CHAN_W (CHAN_W)
    ) u_rr_arbiter (
        .req       (req),
        .rr_ptr    (rr_ptr_q),
        .grant     (arb_onehot),
        .grant_idx (arb_idx)
    );

    always_comb begin
        for (int i = 0; i < NUM_IN; i++) begin
            payload[i] = {in_data[i*DATA_W +: DATA_W],
                          in_error[i*ERR_W +: ERR_W],
                          in_startofpacket[i],
                          in_endofpacket[i],
                          in_empty[i*EMPTY_W +: EMPTY_W]};
        end
    end

    assign sel_payload = payload[grant_q];
    assign {out_data, out_error, out_startofpacket, out_endofpacket, out_empty} = sel_payload;
    assign out_channel = grant_q;
    assign proto_err   = proto_err_q;

    // The granted source is wired straight through; IDLE is the mandatory bubble cycle.
    always_comb begin
        out_valid = 1'b0;
        in_ready  = '0;
        accept    = 1'b0;
        if (state_q == BUSY) begin
            out_valid         = in_valid[grant_q];
            in_ready[grant_q] = out_ready;
            accept            = in_valid[grant_q] & out_ready;
        end
    end

    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        rr_ptr_d    = rr_ptr_q;
        mid_pkt_d   = mid_pkt_q;
        proto_err_d = proto_err_q & ~proto_err_clr;
        case (state_q)
            IDLE: begin
                if (|(in_valid & ~in_startofpacket)) begin
                    proto_err_d = 1'b1;
                end
                if (|arb_onehot) begin
                    grant_d   = arb_idx;
                    mid_pkt_d = 1'b0;
                    state_d   = BUSY;
                end
            end
            BUSY: begin
                if (accept) begin
                    mid_pkt_d = 1'b1;
                    // A second sop inside a packet means the source dropped an eop.
                    if (mid_pkt_q && out_startofpacket) begin
                        proto_err_d = 1'b1;
                    end
                    if (out_endofpacket) begin
                        rr_ptr_d = grant_q;
                        state_d  = IDLE;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            grant_q     <= '0;
            rr_ptr_q    <= CHAN_W'(NUM_IN - 1);
            mid_pkt_q   <= 1'b0;
            proto_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            rr_ptr_q    <= rr_ptr_d;
            mid_pkt_q   <= mid_pkt_d;
            proto_err_q <= proto_err_d;
        end
    end

endmodule

// File: tb/tb_avalon_st_packet_arbiter.sv
// Scoreboard bench: sources replay per-source packet queues, a negedge monitor checks the link.
module tb_avalon_st_packet_arbiter;

    localparam int N  = 4;
    localparam int DW = 32;
    localparam int EW = 6;
    localparam int MW = 2;
    localparam int PW = DW + EW + 2 + MW;

    logic            clk = 1'b0;
    logic            reset_n = 1'b0;
    logic [N-1:0]    in_valid, in_ready, in_sop, in_eop;
    logic [N*DW-1:0] in_data;
    logic [N*EW-1:0] in_error;
    logic [N*MW-1:0] in_empty;
    logic            out_ready, out_valid, out_sop, out_eop, proto_err, proto_err_clr;
    logic [DW-1:0]   out_data;
    logic [EW-1:0]   out_error;
    logic [MW-1:0]   out_empty;
    logic [1:0]      out_channel;

    always #5 clk = ~clk;

    avalon_st_packet_arbiter #(.NUM_IN(N), .CHAN_W(2)) dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .in_valid          (in_valid),
        .in_ready          (in_ready),
        .in_data           (in_data),
        .in_error          (in_error),
        .in_startofpacket  (in_sop),
        .in_endofpacket    (in_eop),
        .in_empty          (in_empty),
        .out_ready         (out_ready),
        .out_valid         (out_valid),
        .out_data          (out_data),
        .out_error         (out_error),
        .out_startofpacket (out_sop),
        .out_endofpacket   (out_eop),
        .out_empty         (out_empty),
        .out_channel       (out_channel),
        .proto_err         (proto_err),
        .proto_err_clr     (proto_err_clr)
    );

    // Beat layout: {data, error, sop, eop, empty}.
    logic [PW-1:0] drv_q [N][$];
    logic [PW-1:0] exp_q [N][$];
    int            issued [N];
    int            served [N];
    int            last_src = N - 1;
    int            checks = 0;
    int            fails = 0;
    bit            mon_en = 0, gap_en = 0, rand_ready = 0;
    bit            ready_pat [$];

    task automatic check_eq(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic load_pkt(input int src, input int len);
        logic [PW-1:0] b;
        for (int k = 0; k < len; k++) begin
            b = {$urandom(), 6'($urandom()), (k == 0), (k == len - 1), 2'($urandom())};
            drv_q[src].push_back(b);
            exp_q[src].push_back(b);
        end
        issued[src]++;
    endtask

    // Reference arbitration: next source after the last served one that still owes a packet.
    function automatic int next_src();
        int c;
        for (int k = 1; k <= N; k++) begin
            c = (last_src + k) % N;
            if (issued[c] > served[c]) return c;
        end
        return -1;
    endfunction

    logic [PW-1:0] out_payload, held_payload, mon_exp;
    bit            stall_prev = 0, bubble_due = 0, in_pkt = 0;
    int            cur_ch = 0;

    assign out_payload = {out_data, out_error, out_sop, out_eop, out_empty};

    always @(negedge clk) begin
        if (!reset_n) last_src = N - 1;
        if (!mon_en || !reset_n) begin
            stall_prev = 0;
            bubble_due = 0;
            in_pkt     = 0;
        end else begin
            if (stall_prev) begin
                check_eq("stall_valid", out_valid, 1);
                check_eq("stall_payload", out_payload, held_payload);
            end
            if (bubble_due) begin
                check_eq("bubble_valid", out_valid, 0);
                check_eq("bubble_ready", in_ready, 0);
                bubble_due = 0;
            end
            if (in_pkt) check_eq("ready_only_grant", in_ready & ~(N'(1) << cur_ch), 0);
            if (out_valid && out_ready) begin
                if (!in_pkt) begin
                    cur_ch = next_src();
                    check_eq("rr_channel", out_channel, cur_ch);
                    in_pkt = 1;
                end else begin
                    check_eq("no_interleave", out_channel, cur_ch);
                end
                if (cur_ch >= 0 && exp_q[cur_ch].size() > 0) begin
                    mon_exp = exp_q[cur_ch].pop_front();
                    check_eq("beat_payload", out_payload, mon_exp);
                    if (mon_exp[2]) begin
                        in_pkt     = 0;
                        served[cur_ch]++;
                        last_src   = cur_ch;
                        bubble_due = 1;
                    end
                end else begin
                    check_eq("unexpected_beat", 0, 1);
                    in_pkt = !out_eop;
                end
            end
            stall_prev   = out_valid && !out_ready;
            held_payload = out_payload;
        end
    end

    task automatic run_traffic(input int max_cycles);
        logic [N-1:0]  acc = '0;
        logic [PW-1:0] b;
        int            cyc = 0;
        bit            busy;
        forever begin
            @(posedge clk); #1;
            busy = 0;
            for (int i = 0; i < N; i++) begin
                if (acc[i]) void'(drv_q[i].pop_front());
                if (drv_q[i].size() > 0) begin
                    busy = 1;
                    b = drv_q[i][0];
                    in_data[i*DW +: DW]  = b[PW-1 -: DW];
                    in_error[i*EW +: EW] = b[EW+3:4];
                    in_sop[i]            = b[3];
                    in_eop[i]            = b[2];
                    in_empty[i*MW +: MW] = b[1:0];
                    if (!(in_valid[i] && !acc[i]))
                        in_valid[i] = b[3] || !gap_en || ($urandom_range(0, 3) != 0);
                end else begin
                    in_valid[i] = 1'b0;
                end
            end
            if (ready_pat.size() > 0) out_ready = ready_pat.pop_front();
            else out_ready = rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
            if (!busy) break;
            if (++cyc > max_cycles) begin
                check_eq("traffic_timeout", 64'(cyc), 64'(max_cycles));
                break;
            end
            @(negedge clk);
            acc = in_valid & in_ready;
        end
        in_valid = '0;
        @(negedge clk);
        @(negedge clk);
        for (int i = 0; i < N; i++) begin
            check_eq("sb_drained", exp_q[i].size(), 0);
            drv_q[i].delete();
            exp_q[i].delete();
            served[i] = issued[i];
        end
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        in_valid = '0; in_sop = '0; in_eop = '0; in_data = '0; in_error = '0; in_empty = '0;
        out_ready = 1'b1; proto_err_clr = 1'b0;
        for (int i = 0; i < N; i++) begin
            issued[i] = 0;
            served[i] = 0;
        end
        repeat (2) @(negedge clk);
        check_eq("reset_out_valid", out_valid, 0);
        check_eq("reset_in_ready", in_ready, 0);
        check_eq("reset_channel", out_channel, 0);
        check_eq("reset_proto_err", proto_err, 0);
        @(posedge clk); #1 reset_n = 1'b1;
        mon_en = 1;

        // All sources backlogged with single-beat packets: expect 0,1,2,3,0.
        load_pkt(0, 1); load_pkt(0, 1);
        for (int i = 1; i < N; i++) load_pkt(i, 1);
        run_traffic(200);

        load_pkt(0, 3);
        run_traffic(100);

        ready_pat = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        load_pkt(1, 3);
        run_traffic(100);

        gap_en = 1; rand_ready = 1;
        repeat (4) begin
            for (int i = 0; i < N; i++)
                repeat ($urandom_range(0, 4)) load_pkt(i, $urandom_range(1, 5));
            run_traffic(3000);
        end
        gap_en = 0; rand_ready = 0;
        check_eq("traffic_proto_err", proto_err, 0);

        // Valid without sop in IDLE is not a request and flags an error.
        mon_en = 0;
        out_ready = 1'b1;
        in_sop = '0; in_eop = '0; in_data = '0;
        @(posedge clk); #1 in_valid = 4'b0100;
        @(negedge clk);
        check_eq("nosop_in_ready", in_ready, 0);
        check_eq("nosop_out_valid", out_valid, 0);
        @(posedge clk); #1;
        @(negedge clk);
        check_eq("nosop_proto_err", proto_err, 1);
        proto_err_clr = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        check_eq("set_wins_over_clr", proto_err, 1);
        in_valid = '0;
        @(posedge clk); #1;
        @(negedge clk);
        check_eq("proto_err_cleared", proto_err, 0);
        proto_err_clr = 1'b0;

        // Two sops without eop from source 3: second beat still forwarded.
        @(posedge clk); #1;
        in_valid = 4'b1000; in_sop = 4'b1000; in_data[3*DW +: DW] = 32'hA5A5_0001;
        @(posedge clk); #1;
        @(negedge clk);
        check_eq("sop2_first_valid", out_valid, 1);
        check_eq("sop2_channel", out_channel, 3);
        check_eq("sop2_first_data", out_data, 32'hA5A5_0001);
        @(posedge clk); #1 in_data[3*DW +: DW] = 32'hA5A5_0002;
        @(negedge clk);
        check_eq("sop2_second_data", out_data, 32'hA5A5_0002);
        check_eq("sop2_err_before", proto_err, 0);
        @(posedge clk); #1;
        in_sop = '0; in_eop = 4'b1000; in_data[3*DW +: DW] = 32'hA5A5_0003;
        @(negedge clk);
        check_eq("sop2_proto_err", proto_err, 1);
        check_eq("sop2_third_data", out_data, 32'hA5A5_0003);
        @(posedge clk); #1;
        in_valid = '0; in_eop = '0; proto_err_clr = 1'b1;
        @(posedge clk); #1 proto_err_clr = 1'b0;

        // Move the pointer to source 1, then reset mid-packet of source 2.
        mon_en = 1;
        load_pkt(1, 1);
        run_traffic(50);
        mon_en = 0;
        @(posedge clk); #1;
        in_valid = 4'b0100; in_sop = 4'b0100; in_eop = '0; in_data[2*DW +: DW] = 32'h2222_0001;
        @(posedge clk); #1;
        @(posedge clk); #1;
        in_sop = '0; in_data[2*DW +: DW] = 32'h2222_0002;
        @(negedge clk);
        check_eq("rst_pre_valid", out_valid, 1);
        check_eq("rst_pre_channel", out_channel, 2);
        #1 reset_n = 1'b0;
        #1;
        check_eq("rst_out_valid", out_valid, 0);
        check_eq("rst_in_ready", in_ready, 0);
        check_eq("rst_channel", out_channel, 0);
        in_valid = 4'b0101; in_sop = 4'b0101; in_data[0 +: DW] = 32'h0000_00AA;
        in_data[2*DW +: DW] = 32'h2222_0001;
        @(posedge clk); #1 reset_n = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        check_eq("post_rst_channel", out_channel, 0);
        check_eq("post_rst_valid", out_valid, 1);
        check_eq("post_rst_data", out_data, 32'h0000_00AA);
        in_valid = '0;

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
